// File: rtl/video_pkg.sv
// Shared definitions for the video palette path: colour RAM geometry, the
// byte layout of a palette entry, and channel bit-replication.
package video_pkg;

    localparam int CRAM_AW = 8;
    localparam int CRAM_DW = 8;

    localparam int R_LSB = 0;
    localparam int G_LSB = 3;
    localparam int B_LSB = 6;
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } side_t;

    // Stage-0 carries the sidebands alongside the RAM read, plus a flag that a read was issued.
    typedef struct packed {
        logic  vld;
        side_t side;
    } stage0_t;

    // MSB-first replication of an in_w-bit value into the low out_w bits (out_w <= 8).
    function automatic logic [7:0] chan_expand(input logic [7:0] value,
                                               input int in_w,
                                               input int out_w);
        logic [7:0] res;
        logic [2:0] oi;
        logic [2:0] ii;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < out_w) begin
                oi      = 3'(out_w - 1 - k);
                ii      = 3'(in_w - 1 - (k % in_w));
                res[oi] = value[ii];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/palette_expand.sv
// Combinational decode of one palette byte into three OUT_W-wide colour
// channels (red/green/blue fields, each widened by bit replication).
module palette_expand
    import video_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [CRAM_DW-1:0] byte_in,
    output logic [OUT_W-1:0]   r,
    output logic [OUT_W-1:0]   g,
    output logic [OUT_W-1:0]   b
);

    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;

    always_comb begin
        r8 = chan_expand({5'b0, byte_in[R_LSB +: R_W]}, R_W, OUT_W);
        g8 = chan_expand({5'b0, byte_in[G_LSB +: G_W]}, G_W, OUT_W);
        b8 = chan_expand({6'b0, byte_in[B_LSB +: B_W]}, B_W, OUT_W);
    end

    assign r = r8[OUT_W-1:0];
    assign g = g8[OUT_W-1:0];
    assign b = b8[OUT_W-1:0];

endmodule

// File: rtl/video_palette.sv
// Colour RAM read issue, palette decode and sync/blank alignment, advancing
// on pix_ce. Define VIDEO_TESTBAR_EN to add the test_en colour-bar generator.
module video_palette
    import video_pkg::*;
#(
    parameter bit INVERT = 1'b1,
    parameter int OUT_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_ce,
    input  logic [CRAM_AW-1:0] pix_idx,
    input  logic               pix_hsync,
    input  logic               pix_vsync,
    input  logic               pix_hblank,
    input  logic               pix_vblank,
`ifdef VIDEO_TESTBAR_EN
    input  logic               test_en,
`endif
    output logic [CRAM_AW-1:0] cram_a,
    output logic               cram_r_n,
    input  logic [CRAM_DW-1:0] cram_do,
    output logic [OUT_W-1:0]   vid_r,
    output logic [OUT_W-1:0]   vid_g,
    output logic [OUT_W-1:0]   vid_b,
    output logic               vid_hsync,
    output logic               vid_vsync,
    output logic               vid_blank
);

    stage0_t            s0_q, s0_d;
    logic [CRAM_DW-1:0] d1_q, d1_d;
    side_t              sb1_q, sb1_d;
    logic [OUT_W-1:0]   vid_r_q, vid_r_d;
    logic [OUT_W-1:0]   vid_g_q, vid_g_d;
    logic [OUT_W-1:0]   vid_b_q, vid_b_d;
    side_t              vid_side_q, vid_side_d;

    logic [CRAM_DW-1:0] ram_byte;
    logic [OUT_W-1:0]   exp_r, exp_g, exp_b;

    assign ram_byte = INVERT ? ~cram_do : cram_do;
    assign cram_a   = pix_idx;

    palette_expand #(.OUT_W(OUT_W)) u_expand (
        .byte_in (d1_q),
        .r       (exp_r),
        .g       (exp_g),
        .b       (exp_b)
    );

`ifdef VIDEO_TESTBAR_EN
    logic [8:0] cnt_q, cnt_d;
    logic       ten0_q, ten0_d;
    logic [2:0] bar0_q, bar0_d;

    assign cram_r_n = ~(pix_ce & reset_n & ~test_en);

    // bar0 takes the counter before this strobe's update, so the first pixel after hblank is bar 0, column 0.
    always_comb begin
        cnt_d  = cnt_q;
        ten0_d = ten0_q;
        bar0_d = bar0_q;
        if (pix_ce) begin
            cnt_d  = pix_hblank ? 9'd0 : cnt_q + 9'd1;
            ten0_d = test_en;
            bar0_d = cnt_q[8:6];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            ten0_q <= 1'b0;
            bar0_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ten0_q <= ten0_d;
            bar0_q <= bar0_d;
        end
    end
`else
    assign cram_r_n = ~(pix_ce & reset_n);
`endif

    always_comb begin
        s0_d       = s0_q;
        d1_d       = d1_q;
        sb1_d      = sb1_q;
        vid_r_d    = vid_r_q;
        vid_g_d    = vid_g_q;
        vid_b_d    = vid_b_q;
        vid_side_d = vid_side_q;
        if (pix_ce) begin
            s0_d.vld  = 1'b1;
            s0_d.side = {pix_hsync, pix_vsync, pix_hblank | pix_vblank};
            // Without a read issued since reset, cram_do is stale; feed black instead.
            d1_d      = s0_q.vld ? ram_byte : '0;
`ifdef VIDEO_TESTBAR_EN
            if (ten0_q) begin
                d1_d = {bar0_q[2], bar0_q[2], bar0_q[1], bar0_q[1], bar0_q[1],
                        bar0_q[0], bar0_q[0], bar0_q[0]};
            end
`endif
            sb1_d      = s0_q.side;
            vid_r_d    = sb1_q.blank ? '0 : exp_r;
            vid_g_d    = sb1_q.blank ? '0 : exp_g;
            vid_b_d    = sb1_q.blank ? '0 : exp_b;
            vid_side_d = sb1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q       <= '0;
            d1_q       <= '0;
            sb1_q      <= '0;
            vid_r_q    <= '0;
            vid_g_q    <= '0;
            vid_b_q    <= '0;
            vid_side_q <= '0;
        end else begin
            s0_q       <= s0_d;
            d1_q       <= d1_d;
            sb1_q      <= sb1_d;
            vid_r_q    <= vid_r_d;
            vid_g_q    <= vid_g_d;
            vid_b_q    <= vid_b_d;
            vid_side_q <= vid_side_d;
        end
    end

    assign vid_r     = vid_r_q;
    assign vid_g     = vid_g_q;
    assign vid_b     = vid_b_q;
    assign vid_hsync = vid_side_q.hsync;
    assign vid_vsync = vid_side_q.vsync;
    assign vid_blank = vid_side_q.blank;

endmodule

// File: tb/tb_video_palette.sv
// Bench for video_palette: behavioural colour RAM, queue-based pixel model
// with a two-strobe delay, directed plus randomized pixel streams.
module tb_video_palette;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic [7:0] pix_idx = 8'h00;
    logic       pix_hsync = 1'b0;
    logic       pix_vsync = 1'b0;
    logic       pix_hblank = 1'b0;
    logic       pix_vblank = 1'b0;
    logic [7:0] cram_a;
    logic       cram_r_n;
    logic [7:0] cram_do = 8'h00;
    logic [7:0] vid_r, vid_g, vid_b;
    logic       vid_hsync, vid_vsync, vid_blank;

    int checks = 0;
    int errors = 0;

    // Pixel record: {idx[10:3], hsync[2], vsync[1], blank[0]}
    logic [10:0] exp_q[$];
    logic [7:0]  er = 8'h00, eg = 8'h00, eb = 8'h00;
    logic        ehs = 1'b0, evs = 1'b0, ebl = 1'b0;

    logic [7:0] mem [256];

    video_palette #(.INVERT(1'b1), .OUT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_ce     (pix_ce),
        .pix_idx    (pix_idx),
        .pix_hsync  (pix_hsync),
        .pix_vsync  (pix_vsync),
        .pix_hblank (pix_hblank),
        .pix_vblank (pix_vblank),
        .cram_a     (cram_a),
        .cram_r_n   (cram_r_n),
        .cram_do    (cram_do),
        .vid_r      (vid_r),
        .vid_g      (vid_g),
        .vid_b      (vid_b),
        .vid_hsync  (vid_hsync),
        .vid_vsync  (vid_vsync),
        .vid_blank  (vid_blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cram_r_n) cram_do <= mem[cram_a];
    end

    function automatic logic [7:0] ref_expand(input logic [7:0] v, input int w);
        int acc;
        int filled;
        acc    = 0;
        filled = 0;
        while (filled < 8) begin
            acc    = (acc << w) | int'(v);
            filled = filled + w;
        end
        return 8'(acc >> (filled - 8));
    endfunction

    task automatic chk8(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk1(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag);
        chk8({tag, ".vid_r"}, vid_r, er);
        chk8({tag, ".vid_g"}, vid_g, eg);
        chk8({tag, ".vid_b"}, vid_b, eb);
        chk1({tag, ".vid_hsync"}, vid_hsync, ehs);
        chk1({tag, ".vid_vsync"}, vid_vsync, evs);
        chk1({tag, ".vid_blank"}, vid_blank, ebl);
    endtask

    task automatic clear_expect();
        exp_q.delete();
        er = 8'h00; eg = 8'h00; eb = 8'h00;
        ehs = 1'b0; evs = 1'b0; ebl = 1'b0;
    endtask

    task automatic model_strobe(input logic [10:0] p);
        logic [10:0] q;
        logic [7:0]  colour;
        exp_q.push_back(p);
        if (exp_q.size() > 2) begin
            q      = exp_q.pop_front();
            colour = ~mem[q[10:3]];
            ehs    = q[2];
            evs    = q[1];
            ebl    = q[0];
            if (q[0]) begin
                er = 8'h00; eg = 8'h00; eb = 8'h00;
            end else begin
                er = ref_expand({5'b0, colour[2:0]}, 3);
                eg = ref_expand({5'b0, colour[5:3]}, 3);
                eb = ref_expand({6'b0, colour[7:6]}, 2);
            end
        end else begin
            er = 8'h00; eg = 8'h00; eb = 8'h00;
            ehs = 1'b0; evs = 1'b0; ebl = 1'b0;
        end
    endtask

    task automatic strobe(input logic [7:0] idx, input logic hs, input logic vs,
                          input logic hb, input logic vb, input int gap);
        @(negedge clk);
        pix_idx    = idx;
        pix_hsync  = hs;
        pix_vsync  = vs;
        pix_hblank = hb;
        pix_vblank = vb;
        pix_ce     = 1'b1;
        #1;
        chk8("issue.cram_a", cram_a, idx);
        chk1("issue.cram_r_n", cram_r_n, 1'b0);
        @(posedge clk);
        #1;
        model_strobe({idx, hs, vs, hb | vb});
        check_out("strobe");
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            pix_ce  = 1'b0;
            pix_idx = 8'($urandom);
            @(posedge clk);
            #1;
            check_out("hold");
            chk1("hold.cram_r_n", cram_r_n, 1'b1);
        end
    endtask

    task automatic rand_strobe(input logic [7:0] idx, input int gap);
        logic [3:0] sb;
        sb = 4'($urandom);
        strobe(idx, sb[0], sb[1], sb[2] & sb[3], (sb == 4'hF), gap);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h5A] = 8'h00;
        mem[8'h10] = ~8'b10_011_101;

        // Reset held with pix_ce toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pix_ce  = (i % 2) == 0;
            pix_idx = 8'($urandom);
            #1;
            check_out("reset");
            chk1("reset.cram_r_n", cram_r_n, 1'b1);
        end
        @(negedge clk);
        pix_ce  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_out("idle");
            chk1("idle.cram_r_n", cram_r_n, 1'b1);
        end

        // Single pixel and decode
        strobe(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        strobe(8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        strobe(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk8("single.vid_r", vid_r, 8'hFF);
        chk8("single.vid_g", vid_g, 8'hFF);
        chk8("single.vid_b", vid_b, 8'hFF);
        strobe(8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        chk8("decode.vid_r", vid_r, 8'hB6);
        chk8("decode.vid_g", vid_g, 8'h6D);
        chk8("decode.vid_b", vid_b, 8'hAA);

        // Blanking on one bright pixel between bright neighbours
        strobe(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        strobe(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        strobe(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk1("blank.before", vid_blank, 1'b0);
        chk8("blank.before_r", vid_r, 8'hFF);
        strobe(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk1("blank.pixel", vid_blank, 1'b1);
        chk8("blank.pixel_r", vid_r, 8'h00);
        strobe(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk1("blank.after", vid_blank, 1'b0);
        chk8("blank.after_b", vid_b, 8'hFF);

        // Continuous strobes, then every 3rd clk, incrementing index
        for (int i = 0; i < 40; i++) rand_strobe(8'(i + 8'h80), 0);
        for (int i = 0; i < 40; i++) rand_strobe(8'(i + 8'hA8), 2);

        // Random indices with random spacing
        for (int i = 0; i < 60; i++) rand_strobe(8'($urandom), $urandom_range(0, 4));

        // Reset asserted mid-line
        strobe(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        strobe(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        strobe(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        clear_expect();
        check_out("midreset");
        chk1("midreset.cram_r_n", cram_r_n, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        pix_ce  = 1'b0;
        reset_n = 1'b1;
        strobe(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk8("post_reset1.vid_r", vid_r, 8'h00);
        chk1("post_reset1.hsync", vid_hsync, 1'b0);
        strobe(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk8("post_reset2.vid_g", vid_g, 8'h00);
        chk1("post_reset2.vsync", vid_vsync, 1'b0);
        for (int i = 0; i < 20; i++) rand_strobe(8'($urandom), $urandom_range(0, 2));

        @(negedge clk);
        pix_ce = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_out("final_hold");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
